sum_bcd_display: RTL and testbench
==================================

Name: sum_bcd_display

Overview:
- Downstream consumer of the 4-bit ripple-carry adder's 5-bit sum (range 0..31).
- Converts the binary sum to two BCD digits using a sequential shift-add-3 (double-dabble) FSM.
- Drives two registered 7-segment digit patterns.
- Uses a valid/ready handshake on both input and output, so adder results can be captured from switches/registers and shown on the board display.

Parameters:
- IN_W, 5, input sum width; legal range 1..6 (max value 63 still fits two digits).
- SEG_ACTIVE_LOW, 1, 1 = segment outputs are inverted (lit segment = 0).
- BLANK_LZ, 1, 1 = tens digit is blanked (all segments off) when the tens BCD is 0.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  in_sum is valid.
- in_ready  output  1  block can accept a sum.
- in_sum  input  IN_W  binary sum from the adder (S[4:0]).
- out_valid  output  1  BCD/segment outputs hold a finished conversion.
- out_ready  input  1  consumer accepts the result.
- bcd_tens  output  4  tens digit, 0..6.
- bcd_ones  output  4  ones digit, 0..9.
- seg_tens  output  7  tens segments, bit order {g,f,e,d,c,b,a}.
- seg_ones  output  7  ones segments, same bit order.
- busy  output  1  high in SHIFT state.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State goes to IDLE; in_ready=1; out_valid=0; busy=0; bcd_tens=bcd_ones=0.
  - seg_tens and seg_ones go to all segments off (7'h7F if SEG_ACTIVE_LOW, else 7'h00).
  - Reset overrides everything, including a transfer in progress in SHIFT or DONE; the partial result is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch in_sum into the shift register, clear the 8-bit BCD scratch, load shift counter = IN_W, go to SHIFT.
- SHIFT:
  - in_ready=0, busy=1.
  - One double-dabble step per clock: for each BCD nibble, if value >=5 add 3; then shift {bcd, bin} left by 1 and decrement the counter.
  - After the IN_W-th step, go to DONE and register the outputs in the same edge.
  - Output update: bcd_tens/bcd_ones from the scratch; seg_* through the decode table, with inversion and blanking applied.
- DONE:
  - out_valid=1.
  - All outputs held stable until the handshake completes.
  - On an edge with out_ready=1: go to IDLE; out_valid=0 from the next cycle.
  - bcd_*/seg_* keep their last value (the display persists) until the next DONE entry or reset.
- Latency: out_valid is high exactly IN_W clock cycles after the accepting edge (5 for default).
- Throughput: one sum per IN_W+2 cycles minimum.
- Handshake rules:
  - in_valid while not in IDLE is ignored; no input buffering.
  - out_valid never drops without out_ready.
- Decode table (active-high, {g..a}):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - BCD >9 cannot occur; decode it as all-off.
- Blanking: when BLANK_LZ=1 and tens=0, seg_tens=off. The ones digit is never blanked.
- Width rules:
  - Scratch is 8 bits (two nibbles).
  - in_sum is zero-extended internally; no value overflows for IN_W<=6.

Test Plan:
1. Reset, then in_sum=0 with out_ready=1 -> out_valid 5 cycles after accept; bcd_tens=0, bcd_ones=0; seg_tens=7'h7F (blank, active-low); seg_ones=7'h40.
2. in_sum=31 (adder 15+15+1) -> bcd 3/1; seg_tens=7'h30, seg_ones=7'h79; in_ready low for cycles 1..6 after accept.
3. in_sum=19, out_ready held 0 for 10 cycles -> out_valid and all outputs stay at 1/9 (seg_tens=7'h79, seg_ones=7'h10); in_valid pulses during the stall are ignored; after out_ready=1, in_ready=1 on the next cycle.
4. rst asserted on the 3rd SHIFT cycle of in_sum=27 -> next cycle IDLE, out_valid=0, bcd=0/0, seg=7'h7F/7'h7F; no output for 27 ever appears.
5. Exhaustive sweep 0..31 back-to-back with in_valid and out_ready held at 1 -> each result matches sum/10 and sum%10; one result every 7 cycles.
6. SEG_ACTIVE_LOW=0, BLANK_LZ=0, in_sum=5 -> seg_tens=7'h3F, seg_ones=7'h6D.

Source files
------------

// File: rtl/sum_bcd_display_if.sv
// Handshake bundle between the adder-side producer/display consumer and the BCD converter.
// master = bench/board side driving sums and accepting results; slave = converter.
interface sum_bcd_display_if #(
  parameter int IN_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_sum;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      bcd_tens;
  logic [3:0]      bcd_ones;
  logic [6:0]      seg_tens;
  logic [6:0]      seg_ones;
  logic            busy;

  modport master (
    output in_valid, in_sum, out_ready,
    input  in_ready, out_valid, bcd_tens, bcd_ones, seg_tens, seg_ones, busy
  );

  modport slave (
    input  in_valid, in_sum, out_ready,
    output in_ready, out_valid, bcd_tens, bcd_ones, seg_tens, seg_ones, busy
  );
endinterface

// File: rtl/sum_bcd_display.sv
// Sequential double-dabble converter: binary adder sum -> two BCD digits -> two 7-segment patterns.
// Handshake: a transfer happens on a rising edge where valid && ready; valid never drops without ready.
module sum_bcd_display #(
  parameter int IN_W           = 5,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LZ       = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  sum_bcd_display_if.slave    bus,
  output logic [1:0]          state_o
);

  localparam int          CNT_W   = $clog2(IN_W + 1);
  localparam logic [6:0]  SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [IN_W-1:0]  bin_q;
  logic [7:0]       bcd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [3:0]       bcd_tens_q;
  logic [3:0]       bcd_ones_q;
  logic [6:0]       seg_tens_q;
  logic [6:0]       seg_ones_q;

  logic [3:0] tens_adj;
  logic [3:0] ones_adj;
  logic [7:0] bcd_d;
  logic [6:0] seg_tens_d;
  logic [6:0] seg_ones_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // One double-dabble step: add-3 correction on each nibble, then shift the next binary bit in.
  always_comb begin
    tens_adj   = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
    ones_adj   = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    bcd_d      = ({tens_adj, ones_adj} << 1) | {7'd0, bin_q[IN_W-1]};
    seg_tens_d = seg_decode(bcd_d[7:4]);
    if (BLANK_LZ && (bcd_d[7:4] == 4'd0)) begin
      seg_tens_d = 7'h00;
    end
    seg_ones_d = seg_decode(bcd_d[3:0]);
    if (SEG_ACTIVE_LOW) begin
      seg_tens_d = ~seg_tens_d;
      seg_ones_d = ~seg_ones_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      bcd_tens_q  <= 4'd0;
      bcd_ones_q  <= 4'd0;
      seg_tens_q  <= SEG_OFF;
      seg_ones_q  <= SEG_OFF;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            bin_q      <= bus.in_sum;
            bcd_q      <= 8'd0;
            cnt_q      <= CNT_W'(IN_W);
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= bcd_d;
          bin_q <= bin_q << 1;
          cnt_q <= cnt_q - CNT_W'(1);
          // Last step: publish the result on the same edge the scratch completes.
          if (cnt_q == CNT_W'(1)) begin
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            bcd_tens_q  <= bcd_d[7:4];
            bcd_ones_q  <= bcd_d[3:0];
            seg_tens_q  <= seg_tens_d;
            seg_ones_q  <= seg_ones_d;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.bcd_tens  = bcd_tens_q;
  assign bus.bcd_ones  = bcd_ones_q;
  assign bus.seg_tens  = seg_tens_q;
  assign bus.seg_ones  = seg_ones_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_sum_bcd_display.sv
// Directed bench for sum_bcd_display: default-parameter instance plus a non-inverted, non-blanking one.
module tb_sum_bcd_display;

  localparam int IN_W = 5;
  localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  sum_bcd_display_if #(.IN_W(IN_W)) bus_a ();
  sum_bcd_display_if #(.IN_W(IN_W)) bus_b ();
  logic [1:0] state_a;
  logic [1:0] state_b;

  sum_bcd_display #(.IN_W(IN_W), .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave), .state_o(state_a)
  );

  sum_bcd_display #(.IN_W(IN_W), .SEG_ACTIVE_LOW(1'b0), .BLANK_LZ(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave), .state_o(state_b)
  );

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg_al(input logic [3:0] d, input bit blank);
    return blank ? 7'h7F : ~SEG_TAB[d];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic accept_a(input logic [IN_W-1:0] sum);
    bus_a.in_sum   = sum;
    bus_a.in_valid = 1'b1;
    step();
    bus_a.in_valid = 1'b0;
  endtask

  // Counts edges until out_valid; an expired budget is a failed check.
  task automatic wait_valid_a(input int budget, output int edges);
    edges = 0;
    while (bus_a.out_valid !== 1'b1 && edges < budget) begin
      step();
      edges++;
    end
    if (bus_a.out_valid !== 1'b1) check("wait_out_valid_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   edges;
    int   last_cyc;
    bit   seen;
    logic [7:0] e;

    bus_a.in_valid = 1'b0; bus_a.in_sum = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_sum = '0; bus_b.out_ready = 1'b0;
    rst = 1'b1;
    step(2);

    check("rst_state",     state_a,          32'd0);
    check("rst_in_ready",  bus_a.in_ready,   32'd1);
    check("rst_out_valid", bus_a.out_valid,  32'd0);
    check("rst_busy",      bus_a.busy,       32'd0);
    check("rst_bcd_tens",  bus_a.bcd_tens,   32'd0);
    check("rst_bcd_ones",  bus_a.bcd_ones,   32'd0);
    check("rst_seg_tens",  bus_a.seg_tens,   32'h7F);
    check("rst_seg_ones",  bus_a.seg_ones,   32'h7F);
    check("rst_b_seg_tens", bus_b.seg_tens,  32'h00);
    rst = 1'b0;

    // Zero: latency 5, blank tens, active-low '0'.
    bus_a.out_ready = 1'b1;
    accept_a(5'd0);
    check("t1_busy",      bus_a.busy,      32'd1);
    check("t1_state",     state_a,         32'd1);
    step(4);
    check("t1_early_valid", bus_a.out_valid, 32'd0);
    step();
    check("t1_valid",     bus_a.out_valid, 32'd1);
    check("t1_bcd_tens",  bus_a.bcd_tens,  32'd0);
    check("t1_bcd_ones",  bus_a.bcd_ones,  32'd0);
    check("t1_seg_tens",  bus_a.seg_tens,  32'h7F);
    check("t1_seg_ones",  bus_a.seg_ones,  32'h40);
    step();
    check("t1_valid_drop", bus_a.out_valid, 32'd0);
    check("t1_in_ready",  bus_a.in_ready,  32'd1);

    // 31: in_ready low for six cycles after accept.
    accept_a(5'd31);
    check("t2_in_ready_c1", bus_a.in_ready, 32'd0);
    for (int i = 2; i <= 6; i++) begin
      step();
      check($sformatf("t2_in_ready_c%0d", i), bus_a.in_ready, 32'd0);
    end
    check("t2_valid",     bus_a.out_valid, 32'd1);
    check("t2_bcd_tens",  bus_a.bcd_tens,  32'd3);
    check("t2_bcd_ones",  bus_a.bcd_ones,  32'd1);
    check("t2_seg_tens",  bus_a.seg_tens,  32'h30);
    check("t2_seg_ones",  bus_a.seg_ones,  32'h79);
    step();
    check("t2_in_ready_back", bus_a.in_ready, 32'd1);

    // 19 with a 10-cycle consumer stall and spurious in_valid pulses.
    bus_a.out_ready = 1'b0;
    accept_a(5'd19);
    step(4);
    for (int i = 0; i < 10; i++) begin
      bus_a.in_sum   = 5'd7;
      bus_a.in_valid = (i % 2 == 0);
      step();
      check($sformatf("t3_valid_%0d", i),    bus_a.out_valid, 32'd1);
      check($sformatf("t3_tens_%0d", i),     bus_a.bcd_tens,  32'd1);
      check($sformatf("t3_ones_%0d", i),     bus_a.bcd_ones,  32'd9);
      check($sformatf("t3_seg_tens_%0d", i), bus_a.seg_tens,  32'h79);
      check($sformatf("t3_seg_ones_%0d", i), bus_a.seg_ones,  32'h10);
    end
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    step();
    check("t3_in_ready",     bus_a.in_ready,  32'd1);
    check("t3_valid_drop",   bus_a.out_valid, 32'd0);
    check("t3_state_idle",   state_a,         32'd0);
    check("t3_persist_ones", bus_a.bcd_ones,  32'd9);

    // 27 aborted by reset during the third SHIFT cycle.
    accept_a(5'd27);
    step(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t4_state",     state_a,         32'd0);
    check("t4_valid",     bus_a.out_valid, 32'd0);
    check("t4_in_ready",  bus_a.in_ready,  32'd1);
    check("t4_busy",      bus_a.busy,      32'd0);
    check("t4_bcd_tens",  bus_a.bcd_tens,  32'd0);
    check("t4_bcd_ones",  bus_a.bcd_ones,  32'd0);
    check("t4_seg_tens",  bus_a.seg_tens,  32'h7F);
    check("t4_seg_ones",  bus_a.seg_ones,  32'h7F);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus_a.out_valid === 1'b1) seen = 1'b1;
    end
    check("t4_no_stale_result", {31'd0, seen}, 32'd0);

    // Back-to-back sweep 0..31, one result every 7 cycles.
    bus_a.out_ready = 1'b1;
    bus_a.in_valid  = 1'b1;
    last_cyc = 0;
    for (int s = 0; s < 32; s++) begin
      bus_a.in_sum = 5'(s);
      check($sformatf("t5_in_ready_%0d", s), bus_a.in_ready, 32'd1);
      step();
      exp_q.push_back({4'(s / 10), 4'(s % 10)});
      wait_valid_a(10, edges);
      check($sformatf("t5_latency_%0d", s), edges, 32'd5);
      e = exp_q.pop_front();
      check($sformatf("t5_tens_%0d", s),     bus_a.bcd_tens, {28'd0, e[7:4]});
      check($sformatf("t5_ones_%0d", s),     bus_a.bcd_ones, {28'd0, e[3:0]});
      check($sformatf("t5_seg_tens_%0d", s), bus_a.seg_tens, {25'd0, exp_seg_al(e[7:4], e[7:4] == 4'd0)});
      check($sformatf("t5_seg_ones_%0d", s), bus_a.seg_ones, {25'd0, exp_seg_al(e[3:0], 1'b0)});
      if (s > 0) check($sformatf("t5_period_%0d", s), cyc - last_cyc, 32'd7);
      last_cyc = cyc;
      step();
    end
    bus_a.in_valid = 1'b0;

    // Non-inverted, unblanked instance: 5 shows a lit '0' in the tens position.
    bus_b.in_sum    = 5'd5;
    bus_b.in_valid  = 1'b1;
    bus_b.out_ready = 1'b1;
    step();
    bus_b.in_valid = 1'b0;
    edges = 0;
    while (bus_b.out_valid !== 1'b1 && edges < 10) begin
      step();
      edges++;
    end
    check("t6_latency",  edges,          32'd5);
    check("t6_bcd_ones", bus_b.bcd_ones, 32'd5);
    check("t6_seg_tens", bus_b.seg_tens, 32'h3F);
    check("t6_seg_ones", bus_b.seg_ones, 32'h6D);
    step();
    check("t6_state_idle", state_b, 32'd0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
